// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - RV32I opcode constants, format codes and pipeline request record
package instr_encoder_pkg;

    localparam logic [6:0] INST_TYPE_I  = 7'b0010011;
    localparam logic [6:0] INST_TYPE_L  = 7'b0000011;
    localparam logic [6:0] INST_TYPE_JI = 7'b1100111;
    localparam logic [6:0] INST_TYPE_S  = 7'b0100011;
    localparam logic [6:0] INST_TYPE_B  = 7'b1100011;
    localparam logic [6:0] INST_LUI     = 7'b0110111;
    localparam logic [6:0] INST_AUIPC   = 7'b0010111;
    localparam logic [6:0] INST_JAL     = 7'b1101111;
    localparam logic [6:0] INST_TYPE_R  = 7'b0110011;

    localparam logic [31:0] INST_NOP = 32'h00000013;

    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_U   = 3'd3;
    localparam logic [2:0] FMT_J   = 3'd4;
    localparam logic [2:0] FMT_R   = 3'd5;
    localparam logic [2:0] FMT_BAD = 3'd6;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } req_t;

    function automatic logic [2:0] fmt_of(input logic [6:0] op);
        case (op)
            INST_TYPE_I, INST_TYPE_L, INST_TYPE_JI: fmt_of = FMT_I;
            INST_TYPE_S:                            fmt_of = FMT_S;
            INST_TYPE_B:                            fmt_of = FMT_B;
            INST_LUI, INST_AUIPC:                   fmt_of = FMT_U;
            INST_JAL:                               fmt_of = FMT_J;
            INST_TYPE_R:                            fmt_of = FMT_R;
            default:                                fmt_of = FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// rtl/instr_encoder_pack.sv - combinational field packer and immediate range check
module instr_pack
    import instr_encoder_pkg::*;
(
    input  req_t        req,
    output logic [31:0] word,
    output logic        range_err
);

    logic [31:0] imm;
    logic [31:0] raw;

    always_comb begin
        imm       = req.imm;
        raw       = {25'b0, req.opcode};
        range_err = 1'b0;
        case (req.fmt)
            FMT_I: begin
                range_err = (imm[31:11] != {21{imm[11]}});
                raw = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            end
            FMT_S: begin
                range_err = (imm[31:11] != {21{imm[11]}});
                raw = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
            end
            FMT_B: begin
                range_err = (imm[31:12] != {20{imm[12]}}) | imm[0];
                raw = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                       imm[4:1], imm[11], req.opcode};
            end
            FMT_U: begin
                range_err = (imm[11:0] != 12'd0);
                raw = {imm[31:12], req.rd, req.opcode};
            end
            FMT_J: begin
                range_err = (imm[31:20] != {12{imm[20]}}) | imm[0];
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
            end
            FMT_R: begin
                raw = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            end
            default: range_err = 1'b1;
        endcase
        // Illegal requests still emit a harmless word so the consumer never sees garbage.
        word = range_err ? INST_NOP : raw;
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage valid/ready RV32I instruction encoder with error counter
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          in_opcode,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs1,
    input  logic [4:0]          in_rs2,
    input  logic [2:0]          in_funct3,
    input  logic [6:0]          in_funct7,
    input  logic [BITWIDTH-1:0] in_imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_instr,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    logic        s1_valid;
    req_t        s1_req;
    logic        s2_ready;
    logic [31:0] pack_word;
    logic        pack_err;

    // S2 can take a new word when empty or when its current word leaves this cycle.
    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_req.fmt    <= fmt_of(in_opcode);
                s1_req.opcode <= in_opcode;
                s1_req.rd     <= in_rd;
                s1_req.rs1    <= in_rs1;
                s1_req.rs2    <= in_rs2;
                s1_req.funct3 <= in_funct3;
                s1_req.funct7 <= in_funct7;
                s1_req.imm    <= in_imm;
            end
        end
    end

    instr_pack u_pack (
        .req       (s1_req),
        .word      (pack_word),
        .range_err (pack_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= pack_word;
                out_err   <= pack_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && out_err && (err_cnt != {ERRCNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - table-driven scoreboard bench for instr_encoder
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    instr_encoder #(.BITWIDTH(32), .ERRCNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } sb_t;

    vec_t        tbl[$];
    sb_t         sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          exp_errcnt = 0;
    bit          chk_lat = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic [31:0] exp, input logic exp_err);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.exp = exp; v.exp_err = exp_err;
        return v;
    endfunction

    // Monitor: samples 3 time units after the falling edge, i.e. well before the next rising edge.
    always begin
        sb_t e;
        @(negedge clk);
        #3;
        if (!rst) begin
            if (prev_hold) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_stable", out_instr, held);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected no output", out_instr);
                end else begin
                    e = sbq.pop_front();
                    check("instr", out_instr, e.instr);
                    check("err", {31'b0, out_err}, {31'b0, e.err});
                    if (chk_lat) check("latency", cyc, e.cyc + 2);
                    if (e.err) exp_errcnt++;
                end
            end
            prev_hold = out_valid && !out_ready;
            held = out_instr;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic send(input vec_t v);
        int  n;
        bit  acc;
        sb_t e;
        n = 0;
        acc = 1'b0;
        in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        in_valid = 1'b1;
        while (!acc && n < 100) begin
            #3;
            acc = in_ready;
            if (acc) begin
                e.instr = v.exp; e.err = v.exp_err; e.cyc = cyc;
                sbq.push_back(e);
                acc_cnt++;
            end
            n++;
            @(negedge clk);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected accept within 100 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        check("drain", sbq.size(), 32'd0);
    endtask

    initial begin
        int base;
        tbl.push_back(mk(INST_TYPE_I, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFF00093, 0));
        tbl.push_back(mk(INST_TYPE_S, 0, 2, 1, 2, 0, 32'd8,        32'h00112423, 0));
        tbl.push_back(mk(INST_LUI,    5, 0, 0, 0, 0, 32'h12345000, 32'h123452B7, 0));
        tbl.push_back(mk(INST_TYPE_B, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'hFE000EE3, 0));
        tbl.push_back(mk(INST_JAL,    1, 0, 0, 0, 0, 32'h00000800, 32'h001000EF, 0));
        tbl.push_back(mk(INST_TYPE_B, 0, 0, 0, 0, 0, 32'd3,        INST_NOP,     1));
        tbl.push_back(mk(INST_TYPE_I, 0, 0, 0, 0, 0, 32'd2048,     INST_NOP,     1));
        tbl.push_back(mk(INST_LUI,    0, 0, 0, 0, 0, 32'd1,        INST_NOP,     1));
        tbl.push_back(mk(INST_TYPE_R, 3, 1, 2, 0, 7'h00, 32'hDEADBEEF, 32'h002081B3, 0));
        tbl.push_back(mk(INST_TYPE_R, 3, 1, 2, 0, 7'h20, 32'h00000001, 32'h402081B3, 0));
        tbl.push_back(mk(INST_TYPE_I, 0, 0, 0, 0, 0, 32'd2047,     32'h7FF00013, 0));
        tbl.push_back(mk(INST_TYPE_I, 0, 0, 0, 0, 0, 32'hFFFFF800, 32'h80000013, 0));
        tbl.push_back(mk(INST_TYPE_B, 0, 0, 0, 0, 0, 32'd4094,     32'h7E000FE3, 0));
        tbl.push_back(mk(INST_TYPE_B, 0, 0, 0, 0, 0, 32'hFFFFF000, 32'h80000063, 0));
        tbl.push_back(mk(INST_TYPE_B, 0, 0, 0, 0, 0, 32'hFFFFEFFE, INST_NOP,     1));
        tbl.push_back(mk(INST_JAL,    0, 0, 0, 0, 0, 32'h000FFFFE, 32'h7FFFF06F, 0));
        tbl.push_back(mk(INST_JAL,    0, 0, 0, 0, 0, 32'hFFF00000, 32'h8000006F, 0));
        tbl.push_back(mk(INST_JAL,    0, 0, 0, 0, 0, 32'h00100000, INST_NOP,     1));
        tbl.push_back(mk(7'h7F,       1, 1, 1, 0, 0, 32'd0,        INST_NOP,     1));
        tbl.push_back(mk(INST_TYPE_L, 1, 2, 0, 2, 0, 32'd4,        32'h00412083, 0));
        tbl.push_back(mk(INST_TYPE_JI,0, 1, 0, 0, 0, 32'd0,        32'h00008067, 0));
        tbl.push_back(mk(INST_TYPE_S, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFE000FA3, 0));
        tbl.push_back(mk(INST_AUIPC,  1, 0, 0, 0, 0, 32'h00001000, 32'h00001097, 0));
        tbl.push_back(mk(INST_TYPE_S, 0, 0, 0, 0, 0, 32'hFFFFF7FF, INST_NOP,     1));

        // Reset state
        #8;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", {31'b0, out_err}, 32'd0);
        check("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors, back to back with the consumer always ready
        chk_lat = 1'b1;
        for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
        in_valid = 1'b0;
        drain();
        chk_lat = 1'b0;
        check("err_cnt_table", {16'b0, err_cnt}, exp_errcnt);

        // Stall: consumer blocked for 5 cycles while 8 requests queue up
        base = acc_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(tbl[i]);
                in_valid = 1'b0;
            end
        join_none
        repeat (5) @(negedge clk);
        #1;
        check("stall_accepted", acc_cnt - base, 32'd2);
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        for (int n = 0; n < 100 && acc_cnt < base + 8; n++) @(negedge clk);
        check("stall_all_accepted", acc_cnt - base, 32'd8);
        drain();
        check("err_cnt_stall", {16'b0, err_cnt}, exp_errcnt);

        // Reset with two words in flight: neither may appear afterwards
        out_ready = 1'b0;
        send(tbl[0]);
        send(tbl[1]);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_err_cnt", {16'b0, err_cnt}, 32'd0);
        sbq.delete();
        exp_errcnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("postrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("postrst_in_ready", {31'b0, in_ready}, 32'd1);

        // Pipeline still works after reset
        chk_lat = 1'b1;
        send(tbl[5]);
        send(tbl[2]);
        in_valid = 1'b0;
        drain();
        check("err_cnt_final", {16'b0, err_cnt}, exp_errcnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
